// File: rtl/shl8_iter.sv
// Multi-cycle left shifter: loads an operand and shift amount on start, shifts one
// bit per clock, tracks the last bit out (carry) and any sign change (ovf).
module shl8_iter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = d_in;
                    count_d = shamt;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Overflow is judged on the pre-shift value: bits [W-1] and [W-2]
                // differing means the new sign bit differs from the old one.
                data_d  = {data_q[WIDTH-2:0], 1'b0};
                carry_d = data_q[WIDTH-1];
                ovf_d   = ovf_q | (data_q[WIDTH-1] ^ data_q[WIDTH-2]);
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign d_out = data_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: doc/shl8_iter.md
Name: shl8_iter

Overview:
- Multi-cycle 8-bit left shifter; the left-direction counterpart of the combinational right shifters in the shifter library.
- Loads an operand and a shift amount on a start pulse, then shifts one bit position per clock.
- Reports the last bit shifted out (carry) and any sign change (arithmetic-left overflow).
- Ends with a one-cycle done pulse, for use by sequential datapaths that trade area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits.
- SHW, 3, shift-amount width; legal amounts are 0..2^SHW-1 (0..7).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- d_in  input  WIDTH  operand, captured on accepted start
- shamt  input  SHW  shift amount, captured on accepted start
- d_out  output  WIDTH  result register
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse when result valid
- carry  output  1  last bit shifted out of bit WIDTH-1
- ovf  output  1  sticky: sign bit changed during any shift step

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is asynchronous and active-high.
  - On reset: state=IDLE, d_out=0, carry=0, ovf=0, done=0, busy=0, count=0.
- Registered outputs: all outputs are registered or decoded from state only; no combinational input-to-output path.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Entered on start=1 at edge k: d_out<=d_in, count<=shamt, carry<=0, ovf<=0.
  - If shamt==0, next state is DONE; otherwise next state is SHIFT.
  - start=0 keeps the state in IDLE with all registers held.
- SHIFT, each edge:
  - d_out<={d_out[WIDTH-2:0],1'b0}
  - carry<=d_out[WIDTH-1]
  - ovf<=ovf | (d_out[WIDTH-1]^d_out[WIDTH-2])
  - count<=count-1
  - When count==1 at the edge, next state is DONE.
- DONE:
  - done=1 for exactly one cycle; the next edge returns to IDLE.
  - busy=1 while in DONE.
- Latency: start accepted at edge k gives done=1 in the cycle following edge k+N, where N=shamt. N=0 therefore takes 1 cycle and N=7 takes 8 cycles.
- Hold: after DONE, d_out, carry and ovf hold until the next accepted start. A new load overwrites them.
- Ignored start: start while busy=1 (SHIFT or DONE) is ignored. It is not queued and has no effect on the operation in flight.
- Back-to-back: start asserted in the cycle when done=1 is ignored. It is accepted on the first IDLE cycle, so the minimum issue interval is N+2 cycles.
- Input stability: d_in and shamt only need to be stable at the accepting edge.
- Reset mid-operation: asserting reset in SHIFT or DONE aborts immediately to the reset values. No done pulse is produced.
- Width rules: shift amounts of WIDTH or more are not representable with the default SHW. If SHW is increased, amounts ≥ WIDTH yield d_out=0, with carry equal to the last bit shifted out.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> outputs immediately 0, state IDLE; release and idle 3 cycles -> done never pulses.
- Overflow and carry: d_in=8'h81, shamt=1, start pulse -> done after 1 shift edge; d_out=8'h02, carry=1, ovf=1, busy falls the cycle after done.
- Multi-step shift: d_in=8'h0F, shamt=3 -> d_out steps 1E, 3C, 78; done in cycle after edge k+3; carry=0, ovf=0.
- Zero shift and maximum shift: d_in=8'hA5, shamt=0 -> done in cycle after edge k, d_out=A5, carry=0, ovf=0. Then d_in=8'hFF, shamt=7 -> d_out=8'h80, carry=1, ovf=0, done after edge k+7.
- Start while busy: d_in=8'h40, shamt=2; during SHIFT pulse start with d_in=8'h01, shamt=5 -> ignored; result d_out=8'h00, carry=1, ovf=1. Start held high through done -> second operation accepted only on the first IDLE cycle.
- Reset mid-shift: d_in=8'h55, shamt=6; assert reset after 2 shift edges -> d_out=0, no done. After release, a new start with d_in=8'h03, shamt=2 -> d_out=8'h0C, carry=0, ovf=0.
